// File: rtl/sm_key_ctrl.sv
// Two-key board controller: key0 steps the LED register index, key1 single-steps or toggles free-run.
// Optional key0 auto-repeat is built when SM_KEY_AUTOREPEAT_EN is defined.
module sm_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    output logic [1:0] keyState,
    output logic [4:0] regAddr,
    output logic       run,
    output logic       clkEnable
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("sm_key_ctrl: cycle parameters out of range");
    end

    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] key_state;
    logic [1:0] key_prev_reg;
    logic [1:0] press;
    logic       release1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 2'b11;
            sync2_reg <= 2'b11;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    // Counter only runs while the synchronized level disagrees with the accepted level.
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic [DB_W-1:0] cnt_reg;
        logic            state_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg   <= '0;
                state_reg <= 1'b0;
            end else if (~sync2_reg[gi] == state_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_reg   <= '0;
                state_reg <= ~state_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign key_state[gi] = state_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_prev_reg <= 2'b00;
        else        key_prev_reg <= key_state;
    end

    assign press    = key_state & ~key_prev_reg;
    assign release1 = key_prev_reg[1] & ~key_state[1];

    logic rpt_fire;

`ifdef SM_KEY_AUTOREPEAT_EN
    localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [LG_W-1:0] hold0_cnt_reg;
    logic [RP_W-1:0] rpt_cnt_reg;
    logic            repeating_reg;

    // hold0_cnt_reg holds (cycles since press event - 1) and parks at LONG_CYCLES-1.
    assign rpt_fire = key_state[0] && !press[0] &&
                      (repeating_reg ? (rpt_cnt_reg == RP_W'(REPEAT_CYCLES - 1))
                                     : (hold0_cnt_reg == LG_W'(LONG_CYCLES - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0_cnt_reg <= '0;
            rpt_cnt_reg   <= '0;
            repeating_reg <= 1'b0;
        end else if (!key_state[0] || press[0]) begin
            hold0_cnt_reg <= '0;
            rpt_cnt_reg   <= '0;
            repeating_reg <= 1'b0;
        end else if (!repeating_reg) begin
            if (hold0_cnt_reg == LG_W'(LONG_CYCLES - 1)) begin
                repeating_reg <= 1'b1;
                rpt_cnt_reg   <= '0;
            end else begin
                hold0_cnt_reg <= hold0_cnt_reg + 1'b1;
            end
        end else if (rpt_cnt_reg == RP_W'(REPEAT_CYCLES - 1)) begin
            rpt_cnt_reg <= '0;
        end else begin
            rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    logic [4:0] addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 addr_reg <= '0;
        else if (press[0] || rpt_fire) addr_reg <= addr_reg + 1'b1;
    end

    typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

    state_t          state_reg, state_next;
    logic [LG_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic            run_reg, run_next;
    logic            step;
    logic            ce_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            run_reg      <= 1'b0;
            ce_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            run_reg      <= run_next;
            ce_reg       <= run_reg | step;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        run_next      = run_reg;
        step          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (press[1]) begin
                    state_next    = PRESS;
                    hold_cnt_next = '0;
                end
            end
            PRESS: begin
                // A release landing on the long threshold still counts as long; go straight home.
                if (hold_cnt_reg == LG_W'(LONG_CYCLES - 1)) begin
                    run_next   = ~run_reg;
                    state_next = release1 ? IDLE : HELD;
                end else if (release1) begin
                    state_next = IDLE;
                    step       = ~run_reg;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (release1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign keyState  = key_state;
    assign regAddr   = addr_reg;
    assign run       = run_reg;
    assign clkEnable = ce_reg;

endmodule

// File: tb/tb_sm_key_ctrl.sv
// Self-checking bench for sm_key_ctrl: directed timing cases plus randomized bouncy key actions
// compared against an action-level model (register index, run flag, step pulses).
module tb_sm_key_ctrl;

    localparam int DB = 4;
    localparam int LG = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic [1:0] keyState;
    logic [4:0] regAddr;
    logic       run;
    logic       clkEnable;

    always #5 clk = ~clk;

    sm_key_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .keyState (keyState),
        .regAddr  (regAddr),
        .run      (run),
        .clkEnable(clkEnable)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_addr   = 0;
    int m_run    = 0;

    // Monitor: counts enable-high cycles and flags any cycle where run was set but enable was not.
    int   ce_total    = 0;
    int   follow_viol = 0;
    logic run_d1      = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_d1 = 1'b0;
        end else begin
            if (run_d1 && !clkEnable) follow_viol++;
            if (clkEnable) ce_total++;
            run_d1 = run;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_n = 2'b11;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        m_addr = 0;
        m_run  = 0;
    endtask

    // Press the keys in mask with optional bounce on both edges, hold steady, release, settle.
    task automatic key_action(input logic [1:0] mask, input int hold, input int bin, input int bout);
        for (int i = 0; i < bin; i++) begin
            key_n = ~mask;
            tick(1 + int'($urandom_range(0, 1)));
            key_n = 2'b11;
            tick(1 + int'($urandom_range(0, 1)));
        end
        key_n = ~mask;
        tick(hold);
        for (int i = 0; i < bout; i++) begin
            key_n = 2'b11;
            tick(1 + int'($urandom_range(0, 1)));
            key_n = ~mask;
            tick(1 + int'($urandom_range(0, 1)));
        end
        key_n = 2'b11;
        tick(12);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_addr"}, regAddr, m_addr);
        check({tag, "_run"}, run, m_run);
        check({tag, "_ce"}, clkEnable, m_run);
        check({tag, "_keys"}, keyState, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] mask;
        int         ce0, run_before, hold, tog_t, exp_ar;
        logic       long_p, seen;

        // Reset state
        tick(2);
        check("rst_keys", keyState, 2'b00);
        check("rst_addr", regAddr, 0);
        check("rst_run", run, 0);
        check("rst_ce", clkEnable, 0);
        rst_n = 1'b1;
        tick(3);

        // Bouncy key0 press: one press, keyState six cycles after the last edge
        for (int c = 0; c < 40; c++) begin
            key_n[0] = (c < 10 && ((c / 2) % 2 == 1)) ? 1'b1 : 1'b0;
            tick();
            if (c == 12) check("bounce_key_early", keyState[0], 0);
            if (c == 13) check("bounce_key_edge", keyState[0], 1);
            if (c == 13) check("bounce_addr_early", regAddr, 0);
            if (c == 14) check("bounce_addr_edge", regAddr, 1);
        end
        key_n = 2'b11;
        tick(12);
        m_addr = 1;
        check_state("bounce");

        // 32 clean presses from reset walk 1..31 then wrap to 0
        do_reset();
        for (int i = 0; i < 32; i++) begin
            key_action(2'b01, 6 + int'($urandom_range(0, 3)), 0, 0);
            m_addr = (m_addr + 1) % 32;
            check($sformatf("step_addr_%0d", i), regAddr, m_addr);
        end

        // Short key1 press with run=0: exactly one enable cycle, seventh cycle after release
        do_reset();
        key_n = 2'b01;
        tick(10);
        key_n = 2'b11;
        for (int t = 1; t <= 9; t++) begin
            tick();
            check($sformatf("step_ce_t%0d", t), clkEnable, (t == 7) ? 1 : 0);
        end
        tick(4);
        check_state("short_step");

        // Long key1 press: run toggles, enable follows one cycle later
        key_n = 2'b01;
        seen  = 1'b0;
        tog_t = -10;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (!seen && run) begin
                seen  = 1'b1;
                tog_t = t;
                check("ce_lags_toggle", clkEnable, 0);
            end else if (seen && t == tog_t + 1) begin
                check("ce_after_toggle", clkEnable, 1);
            end
        end
        check("run_toggled", seen, 1);
        check("run_toggle_window", (tog_t >= 24 && tog_t <= 28), 1);
        key_n = 2'b11;
        tick(12);
        m_run = 1;
        check_state("long_on");
        ce0 = ce_total;
        key_action(2'b10, 7, 1, 1);
        check_state("short_while_run");
        check("ce_follows_run", follow_viol, 0);
        key_action(2'b10, 35, 0, 0);
        m_run = 0;
        check_state("long_off");

        // Reset mid-hold: key1 in PRESS at count 15 with run=1 and a nonzero index
        key_action(2'b10, 32, 0, 0);
        key_action(2'b01, 7, 0, 0);
        m_run  = 1;
        m_addr = (m_addr + 1) % 32;
        check_state("pre_reset");
        key_n = 2'b01;
        tick(22);
        ce0   = ce_total;
        rst_n = 1'b0;
        #1;
        check("async_keys", keyState, 2'b00);
        check("async_addr", regAddr, 0);
        check("async_run", run, 0);
        check("async_ce", clkEnable, 0);
        tick(3);
        rst_n = 1'b1;
        m_run = 0;
        m_addr = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 5) check("reaccept_early", keyState[1], 0);
            if (t == 6) check("reaccept_edge", keyState[1], 1);
        end
        check("no_step_on_reset", ce_total - ce0, 0);
        tick(4);
        key_n = 2'b11;
        tick(12);
        check("fresh_press_step", ce_total - ce0, 1);
        check_state("post_reset");

        // Key0 held 46 cycles after its press event
        key_n = 2'b10;
        for (int i = 0; i < 20 && !keyState[0]; i++) tick();
        check("ar_press_seen", keyState[0], 1);
        tick(40);
        key_n = 2'b11;
        tick(12);
`ifdef SM_KEY_AUTOREPEAT_EN
        exp_ar = 5;
`else
        exp_ar = 1;
`endif
        m_addr = exp_ar;
        check_state("autorepeat");

        // Randomized bouncy actions on key0, key1 or both
        for (int a = 0; a < 40; a++) begin
            mask       = 2'($urandom_range(1, 3));
            long_p     = (mask == 2'b10) && ($urandom_range(0, 2) == 0);
            hold       = long_p ? int'($urandom_range(30, 40)) : int'($urandom_range(6, 9));
            ce0        = ce_total;
            run_before = m_run;
            key_action(mask, hold, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if (mask[0]) m_addr = (m_addr + 1) % 32;
            if (mask[1] && long_p) m_run = 1 - m_run;
            check_state($sformatf("rand%0d", a));
            if (run_before == 0 && m_run == 0)
                check($sformatf("rand%0d_pulses", a), ce_total - ce0, (mask[1] && !long_p) ? 1 : 0);
        end
        check("ce_follows_run_final", follow_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
